// File: rtl/hls_macc_initiator.sv
// hls_macc_initiator
// ------------------
// Master side of the ap_ctrl_hs handshake for one key-locked HLS MACC core.
// It takes one 10-operand job from the host, holds the operands on in1..in10,
// pulses the core with ap_start and collects out1..out3 on their ap_vld strobes.
// The results go back to the host with a status code. A core with a wrong
// locking key shows up as a status error or a timeout, never as a hang.
//
// Ports
//   ap_clk, ap_rst_n             clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready/job_data job port; in1 = job_data[DATA_W-1:0], in10 = top slice
//   ap_start/ap_done/ap_idle/ap_ready   ap_ctrl_hs control to/from the core
//   in1..in10                    operand registers to the core
//   out1..out3, outK_ap_vld      core results and their strobes
//   res_valid/res_ready          result port
//   res_out1..3, res_status      captured results; status 00 ok, 01 missing vld, 10 timeout
//   err_count                    saturating count of non-ok jobs
//   core_idle                    registered copy of ap_idle
//   dbg_state                    current FSM state (0 IDLE, 1 WAIT, 2 RESP)
//
// Handshake rule for both host ports: a transfer happens on a rising edge where
// valid and ready are both 1; the offering side holds its data stable while
// valid is 1 and ready is 0.

module hls_macc_initiator #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [10*DATA_W-1:0]  job_data,
  output logic                  ap_start,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  output logic [DATA_W-1:0]     in1,
  output logic [DATA_W-1:0]     in2,
  output logic [DATA_W-1:0]     in3,
  output logic [DATA_W-1:0]     in4,
  output logic [DATA_W-1:0]     in5,
  output logic [DATA_W-1:0]     in6,
  output logic [DATA_W-1:0]     in7,
  output logic [DATA_W-1:0]     in8,
  output logic [DATA_W-1:0]     in9,
  output logic [DATA_W-1:0]     in10,
  input  logic [DATA_W-1:0]     out1,
  input  logic [DATA_W-1:0]     out2,
  input  logic [DATA_W-1:0]     out3,
  input  logic                  out1_ap_vld,
  input  logic                  out2_ap_vld,
  input  logic                  out3_ap_vld,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_out1,
  output logic [DATA_W-1:0]     res_out2,
  output logic [DATA_W-1:0]     res_out3,
  output logic [1:0]            res_status,
  output logic [CNT_W-1:0]      err_count,
  output logic                  core_idle,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_MISSING = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  logic [10*DATA_W-1:0] r_ops;
  logic [2:0]           r_got;
  logic [TMR_W-1:0]     r_timer;
  logic                 r_ap_start;
  logic                 r_res_valid;
  logic [DATA_W-1:0]    r_res_out1;
  logic [DATA_W-1:0]    r_res_out2;
  logic [DATA_W-1:0]    r_res_out3;
  logic [1:0]           r_res_status;
  logic [CNT_W-1:0]     r_err_count;
  logic                 r_core_idle;

  logic                 w_done;
  logic [2:0]           w_got_all;
  logic                 w_all_vld;
  logic                 w_timeout;
  logic [CNT_W-1:0]     w_err_next;

  // ap_ready is accepted as a completion on its own; a core may raise either.
  assign w_done    = ap_done | ap_ready;
  // A strobe in the same cycle as ap_done still counts towards the result.
  assign w_got_all = r_got | {out3_ap_vld, out2_ap_vld, out1_ap_vld};
  assign w_all_vld = &w_got_all;
  assign w_timeout = (r_timer == TMR_LAST);
  assign w_err_next = (r_err_count == {CNT_W{1'b1}}) ? r_err_count
                                                      : r_err_count + 1'b1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state      <= S_IDLE;
      r_ops        <= '0;
      r_got        <= '0;
      r_timer      <= '0;
      r_ap_start   <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_out1   <= '0;
      r_res_out2   <= '0;
      r_res_out3   <= '0;
      r_res_status <= ST_OK;
      r_err_count  <= '0;
      r_core_idle  <= 1'b0;
    end else begin
      r_core_idle <= ap_idle;
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_ops      <= job_data;
            r_got      <= '0;
            r_timer    <= '0;
            r_ap_start <= 1'b1;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (out1_ap_vld) r_res_out1 <= out1;
          if (out2_ap_vld) r_res_out2 <= out2;
          if (out3_ap_vld) r_res_out3 <= out3;
          r_got <= w_got_all;
          if (w_done) begin
            // Dropping ap_start here lets the core fall back to its idle
            // state without starting a second run.
            r_ap_start   <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_status <= w_all_vld ? ST_OK : ST_MISSING;
            if (!w_all_vld) r_err_count <= w_err_next;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_ap_start   <= 1'b0;
            r_res_valid  <= 1'b1;
            r_res_status <= ST_TIMEOUT;
            r_err_count  <= w_err_next;
            r_state      <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_ap_start  <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Ready is a decode of the state so it is up in the first cycle after reset
  // release, but held low while reset is asserted.
  assign job_ready  = ap_rst_n & (r_state == S_IDLE);
  assign ap_start   = r_ap_start;
  assign res_valid  = r_res_valid;
  assign res_out1   = r_res_out1;
  assign res_out2   = r_res_out2;
  assign res_out3   = r_res_out3;
  assign res_status = r_res_status;
  assign err_count  = r_err_count;
  assign core_idle  = r_core_idle;
  assign dbg_state  = r_state;

  assign in1  = r_ops[0*DATA_W +: DATA_W];
  assign in2  = r_ops[1*DATA_W +: DATA_W];
  assign in3  = r_ops[2*DATA_W +: DATA_W];
  assign in4  = r_ops[3*DATA_W +: DATA_W];
  assign in5  = r_ops[4*DATA_W +: DATA_W];
  assign in6  = r_ops[5*DATA_W +: DATA_W];
  assign in7  = r_ops[6*DATA_W +: DATA_W];
  assign in8  = r_ops[7*DATA_W +: DATA_W];
  assign in9  = r_ops[8*DATA_W +: DATA_W];
  assign in10 = r_ops[9*DATA_W +: DATA_W];

endmodule

// File: tb/tb_hls_macc_initiator.sv
// Directed bench for hls_macc_initiator with a small 4-state core stub.
// Core stub results: out1 = (in1+in2)*in3 + in4*in5 + in6*in7,
//                    out2 = in8*in9 + in10 + in1,  out3 = in1*in10 + in2.
module tb_hls_macc_initiator;
  localparam int DW = 32;
  localparam int EW = 3*DW + 2;

  logic            clk, rst_n;
  logic            job_valid, job_ready;
  logic [10*DW-1:0] job_data;
  logic            ap_start, ap_done, ap_idle, ap_ready;
  logic [DW-1:0]   in1, in2, in3, in4, in5, in6, in7, in8, in9, in10;
  logic [DW-1:0]   out1, out2, out3;
  logic            out1_ap_vld, out2_ap_vld, out3_ap_vld;
  logic            res_valid, res_ready;
  logic [DW-1:0]   res_out1, res_out2, res_out3;
  logic [1:0]      res_status;
  logic [1:0]      err_count;
  logic            core_idle;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // core stub controls
  logic          key_bad, no_done, spur, rdy_en;
  logic [1:0]    core_st;
  int            core_runs;
  logic          core_fire;
  logic [EW-1:0] core_calc;

  hls_macc_initiator #(.DATA_W(DW), .TIMEOUT_CYCLES(8), .CNT_W(2)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5),
    .in6(in6), .in7(in7), .in8(in8), .in9(in9), .in10(in10),
    .out1(out1), .out2(out2), .out3(out3),
    .out1_ap_vld(out1_ap_vld), .out2_ap_vld(out2_ap_vld), .out3_ap_vld(out3_ap_vld),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out1(res_out1), .res_out2(res_out2), .res_out3(res_out3),
    .res_status(res_status), .err_count(err_count),
    .core_idle(core_idle), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [10*DW-1:0] d, input logic [1:0] st);
    logic [DW-1:0] a [10];
    logic [DW-1:0] o1, o2, o3;
    for (int i = 0; i < 10; i++) a[i] = d[i*DW +: DW];
    o1 = (a[0] + a[1]) * a[2] + a[3] * a[4] + a[5] * a[6];
    o2 = a[7] * a[8] + a[9] + a[0];
    o3 = a[0] * a[9] + a[1];
    return {st, o3, o2, o1};
  endfunction

  function automatic logic [10*DW-1:0] mk_seq(input logic [DW-1:0] base);
    logic [10*DW-1:0] d;
    for (int i = 0; i < 10; i++) d[i*DW +: DW] = base + DW'(i);
    return d;
  endfunction

  function automatic logic [10*DW-1:0] mk3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] f);
    logic [10*DW-1:0] d;
    for (int i = 3; i < 10; i++) d[i*DW +: DW] = f;
    d[0*DW +: DW] = a;
    d[1*DW +: DW] = b;
    d[2*DW +: DW] = c;
    return d;
  endfunction

  // ---------------- core stub (4-state ap_ctrl_hs) ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_st   <= 2'd0;
      core_runs <= 0;
    end else begin
      case (core_st)
        2'd0: if (ap_start) begin
          core_st   <= 2'd1;
          core_runs <= core_runs + 1;
        end
        default: core_st <= core_st + 2'd1;
      endcase
    end
  end

  assign core_fire   = ((core_st == 2'd3) && !no_done) || spur;
  assign core_calc   = model({in10, in9, in8, in7, in6, in5, in4, in3, in2, in1}, 2'b00);
  assign out1        = core_calc[0*DW +: DW];
  assign out2        = core_calc[1*DW +: DW];
  assign out3        = core_calc[2*DW +: DW];
  assign ap_done     = core_fire;
  assign ap_ready    = core_fire & rdy_en;
  assign ap_idle     = (core_st == 2'd0);
  assign out1_ap_vld = core_fire;
  assign out2_ap_vld = core_fire & !key_bad;  // wrong key bit drops this strobe
  assign out3_ap_vld = core_fire;

  // ---------------- driver / scoreboard tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [10*DW-1:0] d, input logic [1:0] st);
    exp_q.push_back(model(d, st));
  endtask

  // Offers a job in a cycle where job_ready is high; acceptance is the next edge.
  task automatic offer(input logic [10*DW-1:0] d);
    int n = 0;
    while (!job_ready && n < 50) begin
      step();
      n++;
    end
    chk("offer.job_ready", job_ready, 1);
    job_valid = 1'b1;
    job_data  = d;
  endtask

  // Called in the accept cycle; lat counts cycles to res_valid, starts counts
  // cycles with ap_start high before that.
  task automatic wait_res(output int lat, output int starts);
    step();
    job_valid = 1'b0;
    lat = 1;
    starts = 0;
    while (!res_valid && lat < 60) begin
      if (ap_start) starts++;
      step();
      lat++;
    end
    chk("wait.res_valid", res_valid, 1);
  endtask

  task automatic check_res(input string tag);
    logic [EW-1:0] e;
    chk({tag, ".sb_depth"}, 64'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".status"}, res_status, e[EW-1 -: 2]);
      if (e[EW-1 -: 2] != 2'b10) begin
        chk({tag, ".out1"}, res_out1, e[0*DW +: DW]);
        chk({tag, ".out3"}, res_out3, e[2*DW +: DW]);
      end
      if (e[EW-1 -: 2] == 2'b00) chk({tag, ".out2"}, res_out2, e[1*DW +: DW]);
    end
  endtask

  task automatic finish_res();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10*DW-1:0] d;
    logic [DW-1:0]    hold1;
    int lat, starts, runs0;

    rst_n = 1'b0; job_valid = 1'b0; job_data = '0; res_ready = 1'b0;
    key_bad = 1'b0; no_done = 1'b0; spur = 1'b0; rdy_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.job_ready", job_ready, 0);
    chk("rst.ap_start", ap_start, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.in1", in1, 0);
    chk("rst.in10", in10, 0);
    chk("rst.res_out1", res_out1, 0);
    chk("rst.res_status", res_status, 0);
    chk("rst.err_count", err_count, 0);
    chk("rst.core_idle", core_idle, 0);
    chk("rst.state", dbg_state, 0);
    rst_n = 1'b1;
    #1;
    chk("rel.job_ready", job_ready, 1);
    step(); step();
    chk("rel.core_idle", core_idle, 1);

    // A: correct-key job 2,3,4,1...
    d = mk3(2, 3, 4, 1);
    offer(d); push_exp(d, 2'b00);
    wait_res(lat, starts);
    chk("A.latency", lat, 5);
    chk("A.start_cycles", starts, 4);
    chk("A.res_out1", res_out1, 22);
    chk("A.res_out2", res_out2, 4);
    chk("A.res_out3", res_out3, 5);
    chk("A.in1_hold", in1, 2);
    chk("A.in3_hold", in3, 4);
    chk("A.job_ready_resp", job_ready, 0);
    check_res("A");
    finish_res();
    chk("A.job_ready_idle", job_ready, 1);
    chk("A.state_idle", dbg_state, 0);

    // B: back-to-back with res_ready tied high, ap_ready also raised
    res_ready = 1'b1; rdy_en = 1'b1;
    runs0 = core_runs;
    d = mk_seq(1);
    offer(d); push_exp(d, 2'b00);
    wait_res(lat, starts);
    chk("B1.latency", lat, 5);
    check_res("B1");
    step();
    chk("B.job_ready_after", job_ready, 1);
    chk("B.ap_start_gap", ap_start, 0);
    d = mk_seq(100);
    offer(d); push_exp(d, 2'b00);
    wait_res(lat, starts);
    chk("B2.latency", lat, 5);
    check_res("B2");
    step();
    chk("B.core_runs", core_runs - runs0, 2);
    res_ready = 1'b0; rdy_en = 1'b0;

    // C: wrong key drops out2 strobe
    key_bad = 1'b1;
    d = mk_seq(5);
    offer(d); push_exp(d, 2'b01);
    wait_res(lat, starts);
    chk("C.latency", lat, 5);
    chk("C.res_out1", res_out1, 259);
    chk("C.err_count", err_count, 1);
    check_res("C");
    finish_res();
    key_bad = 1'b0;

    // D: core never completes -> timeout after 8 start cycles
    no_done = 1'b1;
    d = mk_seq(20);
    offer(d); push_exp(d, 2'b10);
    wait_res(lat, starts);
    chk("D.start_cycles", starts, 8);
    chk("D.latency", lat, 9);
    chk("D.err_count", err_count, 2);
    check_res("D");
    finish_res();
    // late/spurious completion while idle
    spur = 1'b1;
    step();
    spur = 1'b0;
    no_done = 1'b0;
    chk("D.spur_state", dbg_state, 0);
    chk("D.spur_res_valid", res_valid, 0);
    chk("D.spur_err_count", err_count, 2);
    chk("D.spur_res_out1", res_out1, 259);
    repeat (4) step();

    // E: result held 10 cycles, next job offered meanwhile
    d = mk_seq(50);
    offer(d); push_exp(d, 2'b00);
    wait_res(lat, starts);
    hold1 = model(d, 2'b00) & {{(EW-DW){1'b0}}, {DW{1'b1}}};
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        job_valid = 1'b1;
        job_data  = mk_seq(60);
      end
      chk("E.hold_valid", res_valid, 1);
      chk("E.hold_out1", res_out1, hold1);
      chk("E.hold_job_ready", job_ready, 0);
      step();
    end
    check_res("E1");
    finish_res();
    chk("E.accept_next", job_ready, 1);
    d = mk_seq(60);
    push_exp(d, 2'b00);
    wait_res(lat, starts);
    chk("E2.latency", lat, 5);
    chk("E2.in1", in1, 60);
    check_res("E2");
    finish_res();

    // F: error counter saturation at 2 bits
    key_bad = 1'b1;
    d = mk_seq(3);
    offer(d); push_exp(d, 2'b01);
    wait_res(lat, starts);
    check_res("F1");
    chk("F1.err_count", err_count, 3);
    finish_res();
    d = mk_seq(4);
    offer(d); push_exp(d, 2'b01);
    wait_res(lat, starts);
    check_res("F2");
    chk("F2.err_sat", err_count, 3);
    finish_res();
    key_bad = 1'b0;

    // G: reset pulse mid-WAIT
    d = mk_seq(9);
    offer(d);
    step();
    job_valid = 1'b0;
    step(); step();
    chk("G.ap_start_wait", ap_start, 1);
    chk("G.core_idle_wait", core_idle, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("G.ap_start_async", ap_start, 0);
    chk("G.res_valid", res_valid, 0);
    chk("G.err_count", err_count, 0);
    chk("G.state", dbg_state, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("G.job_ready_rel", job_ready, 1);

    // H: next job after reset completes normally
    d = mk3(2, 3, 4, 1);
    offer(d); push_exp(d, 2'b00);
    wait_res(lat, starts);
    chk("H.latency", lat, 5);
    chk("H.res_out1", res_out1, 22);
    chk("H.err_count", err_count, 0);
    check_res("H");
    finish_res();
    chk("end.sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
